// File: rtl/uart_cmd_parser.sv
// Parses SYNC/ADDR/DHI/DLO/CSUM frames from a UART byte stream into register writes.
// Latency 1 clock from checksum byte to Wr_Strobe/Csum_Err; no backpressure, one byte per Rx_Ready rising edge.
module uart_cmd_parser #(
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter logic [15:0] TIMEOUT_CLKS = 16'd40000
) (
   input  logic        i_Clock,
   input  logic        i_Reset_n,
   input  logic        Rx_Ready,
   input  logic [7:0]  Rx_Byte,
   output logic        Wr_Strobe,
   output logic [7:0]  Wr_Addr,
   output logic [15:0] Wr_Data,
   output logic        Csum_Err,
   output logic        Timeout_Err,
   output logic [7:0]  Err_Count
);

   typedef enum logic [2:0] {S_HUNT, S_ADDR, S_DHI, S_DLO, S_CSUM} state_t;

   state_t      state_q, state_d;
   logic        rx_rdy_q;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  dhi_q, dhi_d;
   logic [7:0]  dlo_q, dlo_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        wr_strobe_q, wr_strobe_d;
   logic        csum_err_q, csum_err_d;
   logic        tmo_err_q, tmo_err_d;
   logic [7:0]  wr_addr_q, wr_addr_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic        accept;
   logic        expire;

   assign accept = Rx_Ready & ~rx_rdy_q;
   // An accepted byte on the expiry clock takes priority over the timeout.
   assign expire = (state_q != S_HUNT) && !accept && (tmo_cnt_q == TIMEOUT_CLKS - 16'd1);

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q     <= S_HUNT;
         rx_rdy_q    <= 1'b0;
         addr_q      <= 8'h00;
         dhi_q       <= 8'h00;
         dlo_q       <= 8'h00;
         tmo_cnt_q   <= 16'h0000;
         wr_strobe_q <= 1'b0;
         csum_err_q  <= 1'b0;
         tmo_err_q   <= 1'b0;
         wr_addr_q   <= 8'h00;
         wr_data_q   <= 16'h0000;
         err_cnt_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         rx_rdy_q    <= Rx_Ready;
         addr_q      <= addr_d;
         dhi_q       <= dhi_d;
         dlo_q       <= dlo_d;
         tmo_cnt_q   <= tmo_cnt_d;
         wr_strobe_q <= wr_strobe_d;
         csum_err_q  <= csum_err_d;
         tmo_err_q   <= tmo_err_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      dhi_d       = dhi_q;
      dlo_d       = dlo_q;
      wr_strobe_d = 1'b0;
      csum_err_d  = 1'b0;
      tmo_err_d   = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      err_cnt_d   = err_cnt_q;
      tmo_cnt_d   = (state_q == S_HUNT) ? 16'h0000 : tmo_cnt_q + 16'd1;

      if (accept) begin
         tmo_cnt_d = 16'h0000;
         case (state_q)
            S_HUNT: begin
               if (Rx_Byte == SYNC_BYTE) state_d = S_ADDR;
            end
            S_ADDR: begin
               addr_d  = Rx_Byte;
               state_d = S_DHI;
            end
            S_DHI: begin
               dhi_d   = Rx_Byte;
               state_d = S_DLO;
            end
            S_DLO: begin
               dlo_d   = Rx_Byte;
               state_d = S_CSUM;
            end
            S_CSUM: begin
               state_d = S_HUNT;
               if (Rx_Byte == (addr_q ^ dhi_q ^ dlo_q)) begin
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = addr_q;
                  wr_data_d   = {dhi_q, dlo_q};
               end else begin
                  csum_err_d  = 1'b1;
               end
            end
            default: state_d = S_HUNT;
         endcase
      end else if (expire) begin
         state_d   = S_HUNT;
         tmo_cnt_d = 16'h0000;
         tmo_err_d = 1'b1;
      end

      if ((csum_err_d || tmo_err_d) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   assign Wr_Strobe   = wr_strobe_q;
   assign Wr_Addr     = wr_addr_q;
   assign Wr_Data     = wr_data_q;
   assign Csum_Err    = csum_err_q;
   assign Timeout_Err = tmo_err_q;
   assign Err_Count   = err_cnt_q;

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter TIMEOUT_CLKS, default 16'd40000, maximum idle clocks allowed between bytes inside a frame.
REQ-003 i_Clock  input  1  system clock; all logic on rising edge.
REQ-004 i_Reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 Rx_Ready  input  1  byte-valid from upstream UART receiver; one-clock pulse per received byte.
REQ-006 Rx_Byte  input  8  received byte; stable while Rx_Ready high and until next byte.
REQ-007 Wr_Strobe  output  1  one-clock pulse; Wr_Addr/Wr_Data valid.
REQ-008 Wr_Addr  output  8  register address of last good frame.
REQ-009 Wr_Data  output  16  register data of last good frame, {DHI,DLO}.
REQ-010 Csum_Err  output  1  one-clock pulse on checksum mismatch.
REQ-011 Timeout_Err  output  1  one-clock pulse on inter-byte timeout.
REQ-012 Err_Count  output  8  saturating count of Csum_Err plus Timeout_Err events.

Function
REQ-013 Byte acceptance SHALL occur on a clock where Rx_Ready=1 and the registered previous Rx_Ready=0 (rising-edge detect); a held-high Rx_Ready SHALL yield one byte only.
REQ-014 Frame format SHALL be SYNC_BYTE, ADDR, DHI, DLO, CSUM, with CSUM = ADDR ^ DHI ^ DLO.
REQ-015 States SHALL be S_HUNT, S_ADDR, S_DHI, S_DLO, S_CSUM; reset state S_HUNT.
REQ-016 S_HUNT: accepted byte == SYNC_BYTE -> S_ADDR; any other byte SHALL be discarded silently, no error.
REQ-017 S_ADDR/S_DHI/S_DLO: accepted byte SHALL be latched into an internal shadow register and advance to next state; byte value equal to SYNC_BYTE SHALL be treated as data.
REQ-018 S_CSUM: accepted byte SHALL be compared with shadow XOR; state SHALL return to S_HUNT regardless of result.
REQ-019 Checksum match SHALL update Wr_Addr/Wr_Data from the shadow registers and assert Wr_Strobe in the clock after the accepting edge (latency 1 clock).
REQ-020 Checksum mismatch SHALL assert Csum_Err with the same latency; Wr_Addr/Wr_Data SHALL hold previous values, no Wr_Strobe.
REQ-021 Timeout counter (16 bit) SHALL clear on every accepted byte and in S_HUNT, and increment each clock in any other state.
REQ-022 Counter reaching TIMEOUT_CLKS-1 with no accepted byte that clock SHALL force S_HUNT, clear the counter, and pulse Timeout_Err next clock.
REQ-023 Byte accepted on the same clock as timeout expiry SHALL win: the byte is processed normally, no Timeout_Err.
REQ-024 Err_Count SHALL increment by 1 per error pulse and saturate at 8'hFF (no wrap).
REQ-025 Wr_Strobe, Csum_Err, Timeout_Err SHALL each be high for exactly one clock per event and never simultaneously.
REQ-026 Back-to-back frames with no idle gap SHALL be parsed without byte loss.

Reset
REQ-027 Asserting i_Reset_n=0 SHALL immediately, without clock, force S_HUNT, shadow registers 0, timeout counter 0, edge-detect register 0.
REQ-028 Outputs during/after reset: Wr_Strobe=0, Wr_Addr=8'h00, Wr_Data=16'h0000, Csum_Err=0, Timeout_Err=0, Err_Count=8'h00.
REQ-029 Reset mid-frame SHALL discard the partial frame with no error pulse; parsing resumes in S_HUNT on first clock after deassertion.

Verification
REQ-030 Bytes A5 12 34 56 70 -> single Wr_Strobe one clock after fifth byte, Wr_Addr=8'h12, Wr_Data=16'h3456, Err_Count=0.
REQ-031 Bytes A5 12 34 56 71 -> Csum_Err pulse, no Wr_Strobe, Wr_Addr/Wr_Data unchanged, Err_Count=1.
REQ-032 Bytes 00 FF A5 A5 00 00 A5 -> leading 00 FF ignored, Wr_Strobe with Wr_Addr=8'hA5, Wr_Data=16'h0000.
REQ-033 TIMEOUT_CLKS=100, bytes A5 01 then 150 idle clocks -> Timeout_Err at 100th idle clock, then A5 01 02 03 00 -> Wr_Strobe, Wr_Addr=8'h01, Wr_Data=16'h0203.
REQ-034 300 consecutive bad-checksum frames -> Err_Count saturates at 8'hFF; Rx_Ready held high 20 clocks -> only one byte consumed.
REQ-035 i_Reset_n pulsed low asynchronously after A5 12 34 -> all outputs at reset values, then A5 12 34 56 70 -> normal Wr_Strobe.
